matrix_reshape: RTL and testbench

- Parametrised successor to the fixed 5x5 matrix ordering stage.
- Packs a dense, row-major list of r*c elements into a MAX_DIM x MAX_DIM zero-padded grid, either as-is or transposed.
- Walks one grid position per clock, snapshotting all operands at start.
- Sits between the matrix input/entry logic and the arithmetic/display stages.

---
 rtl/matrix_reshape.sv | 165 ++++++++++++++++
 tb/tb_matrix_reshape.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_reshape.sv
// matrix_reshape
// Packs a dense row-major list of r*c elements into a MAX_DIM x MAX_DIM
// zero-padded grid, either as-is (mode 0) or transposed (mode 1). After a
// start the operands are snapshotted and one grid position is produced per
// clock. The finished grid is committed to data_out in a single edge.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   start     single-cycle request, honoured only in IDLE or DONE
//   mode      0 = row-major pack, 1 = transposed pack
//   r, c      source rows / columns (legal 1..MAX_DIM)
//   data_in   dense source list, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   data_out  grid, position row*MAX_DIM+col at [p*DATA_WIDTH +: DATA_WIDTH]
//   out_rows  result rows (r in mode 0, c in mode 1)
//   out_cols  result columns (c in mode 0, r in mode 1)
//   busy      high while walking the grid
//   done      high while a result is being held
//   err       high after a start with illegal dimensions
module matrix_reshape #(
  parameter int DATA_WIDTH = 9,
  parameter int MAX_DIM    = 5,
  parameter int DIM_W      = $clog2(MAX_DIM + 1)
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic                                   mode,
  input  logic [DIM_W-1:0]                       r,
  input  logic [DIM_W-1:0]                       c,
  input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]  data_in,
  output logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]  data_out,
  output logic [DIM_W-1:0]                       out_rows,
  output logic [DIM_W-1:0]                       out_cols,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);

  localparam int N  = MAX_DIM * MAX_DIM;
  localparam int AW = $clog2(N);        // grid position counter
  localparam int IW = $clog2(N + 1);    // source index / offset registers
  localparam int SW = IW + 1;           // base + offset sum

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  src_q [N];
  logic [N*DATA_WIDTH-1:0] grid_q;
  logic [DIM_W-1:0]       r_q, c_q;
  logic                   mode_q;
  logic [AW-1:0]          p;
  logic [DIM_W-1:0]       row, col;
  logic [IW-1:0]          s0;       // mode 0: running in-region index
  logic [IW-1:0]          base;     // mode 1: current output row
  logic [IW-1:0]          offset;   // mode 1: col * c within the row

  logic [DIM_W-1:0]       rows_eff, cols_eff;
  logic                   in_reg;
  logic                   illegal;
  logic [SW-1:0]          sel;
  logic [DATA_WIDTH-1:0]  val;

  always_comb begin
    rows_eff = mode_q ? c_q : r_q;
    cols_eff = mode_q ? r_q : c_q;
    in_reg   = (row < rows_eff) && (col < cols_eff);
    illegal  = (r == '0) || (c == '0) ||
               (r > DIM_W'(MAX_DIM)) || (c > DIM_W'(MAX_DIM));
    sel      = mode_q ? ({1'b0, base} + {1'b0, offset}) : {1'b0, s0};
  end

  // Source select as a compare-mux: out-of-region positions never index the
  // source, so the sum is only meaningful (and bounded by r*c-1) when in_reg.
  always_comb begin
    val = '0;
    if (in_reg) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (sel == SW'(k)) val = src_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      for (int unsigned k = 0; k < N; k++) src_q[k] <= '0;
      grid_q   <= '0;
      r_q      <= '0;
      c_q      <= '0;
      mode_q   <= 1'b0;
      p        <= '0;
      row      <= '0;
      col      <= '0;
      s0       <= '0;
      base     <= '0;
      offset   <= '0;
      data_out <= '0;
      out_rows <= '0;
      out_cols <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (illegal) begin
              state <= IDLE;
              err   <= 1'b1;
              done  <= 1'b0;
            end else begin
              for (int unsigned k = 0; k < N; k++)
                src_q[k] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
              r_q    <= r;
              c_q    <= c;
              mode_q <= mode;
              grid_q <= '0;
              p      <= '0;
              row    <= '0;
              col    <= '0;
              s0     <= '0;
              base   <= '0;
              offset <= '0;
              err    <= 1'b0;
              done   <= 1'b0;
              busy   <= 1'b1;
              state  <= RUN;
            end
          end
        end

        RUN: begin
          grid_q[p*DATA_WIDTH +: DATA_WIDTH] <= val;
          if (in_reg) s0 <= s0 + IW'(1);

          if (col == DIM_W'(MAX_DIM - 1)) begin
            col    <= '0;
            row    <= row + DIM_W'(1);
            base   <= base + IW'(1);
            offset <= '0;
          end else begin
            col <= col + DIM_W'(1);
            if (in_reg) offset <= offset + IW'(c_q);
          end

          if (p == AW'(N - 1)) begin
            // Last position bypasses grid_q so the whole result lands at once.
            data_out <= {val, grid_q[(N-1)*DATA_WIDTH-1:0]};
            out_rows <= rows_eff;
            out_cols <= cols_eff;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            p <= p + AW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_reshape.sv
// Self-checking bench for matrix_reshape: directed and random operations
// compared against an index-arithmetic reference of the reshaped grid.
module tb_matrix_reshape;

  localparam int DW   = 9;
  localparam int MD   = 5;
  localparam int N    = MD * MD;
  localparam int DIMW = $clog2(MD + 1);

  logic                clk;
  logic                reset_n;
  logic                start;
  logic                mode;
  logic [DIMW-1:0]     r, c;
  logic [N*DW-1:0]     data_in;
  logic [N*DW-1:0]     data_out;
  logic [DIMW-1:0]     out_rows, out_cols;
  logic                busy, done, err;

  matrix_reshape #(.DATA_WIDTH(DW), .MAX_DIM(MD)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .mode     (mode),
    .r        (r),
    .c        (c),
    .data_in  (data_in),
    .data_out (data_out),
    .out_rows (out_rows),
    .out_cols (out_cols),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int unsigned src_m    [N];
  int unsigned exp_grid [N];
  int unsigned exp_rows = 0;
  int unsigned exp_cols = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Reference: grid cell (row,col) of the result holds A[row][col] in mode 0
  // and A[col][row] in mode 1, where A is the r x c source matrix.
  task automatic build_expected(input int m, input int rr, input int cc);
    int rows_e, cols_e;
    rows_e = m ? cc : rr;
    cols_e = m ? rr : cc;
    for (int row = 0; row < MD; row++)
      for (int col = 0; col < MD; col++) begin
        if (row < rows_e && col < cols_e)
          exp_grid[row*MD + col] = m ? src_m[col*cc + row] : src_m[row*cc + col];
        else
          exp_grid[row*MD + col] = 0;
      end
    exp_rows = rows_e;
    exp_cols = cols_e;
  endtask

  task automatic pack_src();
    for (int k = 0; k < N; k++) data_in[k*DW +: DW] = DW'(src_m[k]);
  endtask

  task automatic check_grid(input string tag);
    for (int p = 0; p < N; p++)
      check($sformatf("%s_grid[%0d]", tag, p), data_out[p*DW +: DW], exp_grid[p]);
    check({tag, "_rows"}, out_rows, exp_rows);
    check({tag, "_cols"}, out_cols, exp_cols);
  endtask

  task automatic run_op(input string tag, input int m, input int rr, input int cc,
                        input bit scramble);
    logic [N*DW-1:0] prev;
    int unsigned busy_cnt, edges, changed, got_done;
    @(negedge clk);
    mode = m[0];
    r = DIMW'(rr);
    c = DIMW'(cc);
    pack_src();
    start = 1'b1;
    build_expected(m, rr, cc);
    prev = data_out;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    edges = 0; changed = 0; got_done = 0;
    for (int i = 1; i <= N + 10; i++) begin
      @(posedge clk); #1;
      edges = i;
      if (done) begin got_done = 1; break; end
      if (busy) busy_cnt++;
      if (data_out !== prev) changed = 1;
      if (scramble) begin
        for (int k = 0; k < N; k++) data_in[k*DW +: DW] = DW'($urandom);
        r     = DIMW'($urandom);
        c     = DIMW'($urandom);
        mode  = 1'($urandom);
        start = (i == 9);
      end
    end
    start = 1'b0;
    check({tag, "_done"}, got_done, 1);
    check({tag, "_latency"}, edges, N);
    check({tag, "_busy_cycles"}, busy_cnt, N);
    check({tag, "_no_early_out"}, changed, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_err"}, err, 0);
    check_grid(tag);
  endtask

  task automatic illegal_start(input string tag, input int rr, input int cc);
    @(negedge clk);
    r = DIMW'(rr);
    c = DIMW'(cc);
    mode = 1'($urandom);
    for (int k = 0; k < N; k++) data_in[k*DW +: DW] = DW'($urandom);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_err"}, err, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_busy_later"}, busy, 0);
    check_grid(tag);
  endtask

  task automatic random_src();
    for (int k = 0; k < N; k++) src_m[k] = $urandom_range(0, (1 << DW) - 1);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    mode    = 1'b0;
    r       = '0;
    c       = '0;
    data_in = '0;
    #22;
    check("reset_data_out_zero", (data_out == '0) ? 1 : 0, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_rows", out_rows, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 2x3 of 1..6, trailing entries are junk that must not appear.
    for (int k = 0; k < N; k++) src_m[k] = (k < 6) ? k + 1 : 100 + k;
    run_op("rowmajor_2x3", 0, 2, 3, 0);
    run_op("transpose_2x3", 1, 2, 3, 0);

    for (int k = 0; k < N; k++) src_m[k] = k;
    run_op("transpose_5x5", 1, 5, 5, 0);
    check("t5x5_p1", data_out[1*DW +: DW], 5);
    check("t5x5_p24", data_out[24*DW +: DW], 24);

    illegal_start("illegal_r0", 0, 3);
    illegal_start("illegal_c6", 2, 6);
    random_src();
    run_op("after_err", 0, 3, 4, 0);

    random_src();
    run_op("snapshot", 1, 4, 2, 1);

    // Abort a run with reset, then make sure a fresh run is clean.
    random_src();
    @(negedge clk);
    mode = 1'b0; r = 3'd5; c = 3'd5; pack_src(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 12; i++) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrun_reset_out_zero", (data_out == '0) ? 1 : 0, 1);
    check("midrun_reset_busy", busy, 0);
    check("midrun_reset_done", done, 0);
    check("midrun_reset_rows", out_rows, 0);
    @(negedge clk);
    reset_n = 1'b1;
    random_src();
    run_op("after_reset", 1, 3, 5, 0);

    run_op("edge_1x1", 0, 1, 1, 0);
    random_src();
    run_op("edge_5x1_t", 1, 5, 1, 0);
    for (int t = 0; t < 6; t++) begin
      random_src();
      run_op($sformatf("rand%0d", t), $urandom_range(0, 1),
             $urandom_range(1, MD), $urandom_range(1, MD), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
